stream_to_hs_fifo: RTL and testbench

Parametrised successor of the single-register stream-to-handshake adapter: accepts 64-bit-class AXI-Stream words and presents them on an HLS `ap_hs` style output (data, `ap_vld`, `ap_ack`) through a DEPTH-entry FIFO. It sits between the accelerator command/stream fabric and HLS kernel ports that use valid/ack handshakes. It decouples producer and consumer by up to DEPTH words and sustains one transfer per cycle on both sides.

---
 rtl/stream_hs_pkg.sv | 17 +
 rtl/stream_hs_fifo_mem.sv | 27 ++
 rtl/stream_to_hs_fifo.sv | 94 +++++++++
 tb/tb_stream_to_hs_fifo.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/stream_hs_pkg.sv
// Shared sizing helpers for the stream-to-handshake FIFO slice.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
package stream_hs_pkg;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/stream_hs_fifo_mem.sv
// FIFO storage: DEPTH x DATA_WIDTH register array with one synchronous write
// port and one asynchronous read port. Contents are deliberately not reset.
module stream_hs_fifo_mem
    import stream_hs_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [ptr_w(DEPTH)-2:0]       wr_addr,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic [ptr_w(DEPTH)-2:0]       rd_addr,
    output logic [DATA_WIDTH-1:0]         rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stream_to_hs_fifo.sv
// AXI-Stream to ap_hs adapter with a DEPTH-entry FIFO in between.
// Optional occupancy output `level` is enabled by defining STREAM_TO_HS_LEVEL_EN.
module stream_to_hs_fifo
    import stream_hs_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      aresetn,
    input  logic [DATA_WIDTH-1:0]     inStream_tdata,
    input  logic                      inStream_tvalid,
    output logic                      inStream_tready,
    output logic [DATA_WIDTH-1:0]     out_hs,
    output logic                      out_hs_ap_vld,
    input  logic                      out_hs_ap_ack
`ifdef STREAM_TO_HS_LEVEL_EN
    ,
    output logic [lvl_w(DEPTH)-1:0]   level
`endif
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    generate
        if (!depth_ok(DEPTH)) begin : g_depth_check
            $error("stream_to_hs_fifo: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          init_done;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // init_done keeps tready low until the first edge after reset release.
    assign inStream_tready = init_done && !full;
    assign out_hs_ap_vld   = !empty;

    assign push = inStream_tvalid && inStream_tready;
    assign pop  = out_hs_ap_vld && out_hs_ap_ack;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    stream_hs_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (inStream_tdata),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (out_hs)
    );

`ifdef STREAM_TO_HS_LEVEL_EN
    localparam int LW = lvl_w(DEPTH);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            level <= '0;
        end else begin
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_stream_to_hs_fifo.sv
// Directed-vector and scoreboard bench for stream_to_hs_fifo
// (DEPTH=4/64-bit and DEPTH=8/32-bit instances).
module tb_stream_to_hs_fifo;

    logic        clk = 1'b0;
    logic        aresetn;

    logic [63:0] tdata;
    logic        tvalid;
    logic        tready;
    logic [63:0] hs;
    logic        vld;
    logic        ack;

    logic [31:0] tdata8;
    logic        tvalid8;
    logic        tready8;
    logic [31:0] hs8;
    logic        vld8;
    logic        ack8;

`ifdef STREAM_TO_HS_LEVEL_EN
    logic [2:0]  level;
    logic [3:0]  level8;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    stream_to_hs_fifo #(.DATA_WIDTH(64), .DEPTH(4)) dut (
        .clk             (clk),
        .aresetn         (aresetn),
        .inStream_tdata  (tdata),
        .inStream_tvalid (tvalid),
        .inStream_tready (tready),
        .out_hs          (hs),
        .out_hs_ap_vld   (vld),
        .out_hs_ap_ack   (ack)
`ifdef STREAM_TO_HS_LEVEL_EN
        ,
        .level           (level)
`endif
    );

    stream_to_hs_fifo #(.DATA_WIDTH(32), .DEPTH(8)) dut8 (
        .clk             (clk),
        .aresetn         (aresetn),
        .inStream_tdata  (tdata8),
        .inStream_tvalid (tvalid8),
        .inStream_tready (tready8),
        .out_hs          (hs8),
        .out_hs_ap_vld   (vld8),
        .out_hs_ap_ack   (ack8)
`ifdef STREAM_TO_HS_LEVEL_EN
        ,
        .level           (level8)
`endif
    );

    typedef struct {
        logic        tv;
        logic [63:0] d;
        logic        ack;
        logic        e_tr;
        logic        e_vld;
        logic [63:0] e_d;
        int          e_lvl;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_lvl(input string name, input int exp);
`ifdef STREAM_TO_HS_LEVEL_EN
        chk(name, 64'(level), 64'(exp));
`else
        if (exp < 0) $display("note: negative level %0d in %s", exp, name);
`endif
    endtask

    initial begin
        int qd_popped;
        int cyc;
        int sz;
        logic [31:0] qd [$];

        // tv, data, ack | tready, vld, out_hs, level (state seen during the cycle)
        tbl[0]  = '{1'b1, 64'h1,  1'b0, 1'b1, 1'b0, 64'h0,  0};
        tbl[1]  = '{1'b1, 64'h2,  1'b0, 1'b1, 1'b1, 64'h1,  1};
        tbl[2]  = '{1'b1, 64'h3,  1'b0, 1'b1, 1'b1, 64'h1,  2};
        tbl[3]  = '{1'b1, 64'h4,  1'b0, 1'b1, 1'b1, 64'h1,  3};
        tbl[4]  = '{1'b1, 64'h5,  1'b0, 1'b0, 1'b1, 64'h1,  4};
        tbl[5]  = '{1'b1, 64'h5,  1'b1, 1'b0, 1'b1, 64'h1,  4};
        tbl[6]  = '{1'b1, 64'h5,  1'b0, 1'b1, 1'b1, 64'h2,  3};
        tbl[7]  = '{1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 64'h2,  4};
        tbl[8]  = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 64'h2,  4};
        tbl[9]  = '{1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 64'h3,  3};
        tbl[10] = '{1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 64'h4,  2};
        tbl[11] = '{1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 64'h5,  1};
        tbl[12] = '{1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 64'h0,  0};
        tbl[13] = '{1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 64'h0,  0};
        tbl[14] = '{1'b1, 64'h77, 1'b0, 1'b1, 1'b0, 64'h0,  0};
        tbl[15] = '{1'b0, 64'h0,  1'b0, 1'b1, 1'b1, 64'h77, 1};
        tbl[16] = '{1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 64'h77, 1};
        tbl[17] = '{1'b0, 64'h0,  1'b0, 1'b1, 1'b0, 64'h0,  0};

        aresetn = 1'b0;
        tvalid  = 1'b0; tdata  = '0; ack  = 1'b0;
        tvalid8 = 1'b0; tdata8 = '0; ack8 = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tready", 64'(tready), 64'h0);
        chk("rst_vld", 64'(vld), 64'h0);
        chk_lvl("rst_level", 0);
        aresetn = 1'b1;
        #1;
        chk("rel_tready_before_edge", 64'(tready), 64'h0);
        @(posedge clk); #1;

        // Fill / drain / empty-ack / latency vectors
        for (int i = 0; i < 18; i++) begin
            tvalid = tbl[i].tv; tdata = tbl[i].d; ack = tbl[i].ack;
            @(negedge clk);
            chk($sformatf("vec%0d_tready", i), 64'(tready), 64'(tbl[i].e_tr));
            chk($sformatf("vec%0d_vld", i), 64'(vld), 64'(tbl[i].e_vld));
            if (tbl[i].e_vld) chk($sformatf("vec%0d_data", i), hs, tbl[i].e_d);
            chk_lvl($sformatf("vec%0d_level", i), tbl[i].e_lvl);
            @(posedge clk); #1;
        end

        // Streaming: push and ack every cycle, one word per cycle in order
        for (int i = 0; i <= 100; i++) begin
            tvalid = (i < 100); tdata = 64'h100 + 64'(i); ack = 1'b1;
            @(negedge clk);
            if (i > 0) begin
                chk("stream_tready", 64'(tready), 64'h1);
                chk("stream_data", vld ? hs : 64'hDEAD, 64'h100 + 64'(i - 1));
                chk_lvl("stream_level", 1);
            end
            @(posedge clk); #1;
        end
        tvalid = 1'b0; ack = 1'b0;
        @(negedge clk);
        chk("stream_drained_vld", 64'(vld), 64'h0);
        @(posedge clk); #1;

        // Reset mid-stream with three words queued
        for (int i = 0; i < 3; i++) begin
            tvalid = 1'b1; tdata = 64'h10 + 64'(i);
            @(posedge clk); #1;
        end
        tvalid = 1'b0;
        chk("pre_rst_head", hs, 64'h10);
        chk_lvl("pre_rst_level", 3);
        #2;
        aresetn = 1'b0;
        #1;
        chk("midrst_vld", 64'(vld), 64'h0);
        chk("midrst_tready", 64'(tready), 64'h0);
        chk_lvl("midrst_level", 0);
        @(posedge clk);
        @(negedge clk);
        aresetn = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_tready", 64'(tready), 64'h1);
        chk("post_rst_vld", 64'(vld), 64'h0);
        tvalid = 1'b1; tdata = 64'hAA;
        @(posedge clk); #1;
        tvalid = 1'b0;
        chk("post_rst_vld_aa", 64'(vld), 64'h1);
        chk("post_rst_head_aa", hs, 64'hAA);
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        chk("post_rst_empty", 64'(vld), 64'h0);

        // Random handshakes on the DEPTH=8 instance against a queue model
        qd_popped = 0;
        cyc = 0;
        while (qd_popped < 10000 && cyc < 80000) begin
            tvalid8 = 1'($urandom_range(0, 1));
            ack8    = 1'($urandom_range(0, 1));
            tdata8  = $urandom;
            @(negedge clk);
            sz = qd.size();
            chk("rnd_vld", 64'(vld8), 64'(sz > 0));
            chk("rnd_tready", 64'(tready8), 64'(sz < 8));
            if (sz > 0) chk("rnd_data", 64'(hs8), 64'(qd[0]));
`ifdef STREAM_TO_HS_LEVEL_EN
            chk("rnd_level", 64'(level8), 64'(sz));
`endif
            if (ack8 && sz > 0) begin
                void'(qd.pop_front());
                qd_popped++;
            end
            if (tvalid8 && sz < 8) qd.push_back(tdata8);
            @(posedge clk); #1;
            cyc++;
        end
        tvalid8 = 1'b0; ack8 = 1'b0;
        if (qd_popped < 10000) chk("rnd_timeout", 64'(qd_popped), 64'd10000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
